fetch_sequencer: RTL and testbench

- Drives the instruction-fetch side of the RV32I pipeline over a variable-latency instruction memory that uses a request/response handshake.
- Owns the fetch PC and sequences requests to memory.
- Drops stale responses after an EX-stage redirect.
- Owns the IF/ID pipeline register, including stall hold, flush and bubble insertion.
- Sits between the hazard unit / EX-stage branch resolution and the decode stage.

---
 rtl/fetch_sequencer.sv | 148 ++++++++++++++
 tb/tb_fetch_sequencer.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction-fetch front end for the RV32I pipeline.
// Owns the fetch PC, issues one request at a time to a variable-latency
// instruction memory, drops responses made stale by EX-stage redirects and
// maintains the IF/ID pipeline register (stall hold, flush, bubbles).
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallD,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        validD,
    output logic        stallF
);

    // REQ: request driven; WAIT: response pending; HOLD: response parked in
    // the skid buffer while decode stalls; FLUSH: pending response is stale.
    localparam logic [1:0] REQ   = 2'd0;
    localparam logic [1:0] WAIT  = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;
    localparam logic [1:0] FLUSH = 2'd3;

    logic [1:0]  state_q;
    logic [1:0]  state_d;
    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] skid_q;
    logic        handshake;
    logic        deliver;
    logic        capture;
    logic [31:0] deliver_word;

    // The request is suppressed during the reset cycle itself.
    assign imem_req  = (state_q == REQ) && !rst;
    assign imem_addr = {pc_q[31:2], 2'b00};
    assign handshake = imem_req && imem_ready;
    assign stallF    = !((state_q == REQ) && imem_ready);

    // Next-state decode: where to go, and whether a word is handed to IF/ID.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        deliver      = 1'b0;
        capture      = 1'b0;
        deliver_word = imem_rdata;
        case (state_q)
            REQ: begin
                if (handshake) begin
                    state_d = PCSrcE ? FLUSH : WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    if (PCSrcE) begin
                        state_d = REQ;
                    end else if (!stallD) begin
                        deliver = 1'b1;
                        state_d = REQ;
                    end else begin
                        capture = 1'b1;
                        state_d = HOLD;
                    end
                end else if (PCSrcE) begin
                    state_d = FLUSH;
                end
            end
            HOLD: begin
                if (PCSrcE) begin
                    state_d = REQ;
                end else if (!stallD) begin
                    deliver      = 1'b1;
                    deliver_word = skid_q;
                    state_d      = REQ;
                end
            end
            FLUSH: begin
                if (imem_rvalid) begin
                    state_d = REQ;
                end
            end
            default: state_d = REQ;
        endcase
    end

    // A redirect always wins; otherwise the PC advances (mod 2^32) once its word is delivered.
    always_comb begin
        pc_d = pc_q;
        if (PCSrcE) begin
            pc_d = PCTargetE & ~32'h3;
        end else if (deliver) begin
            pc_d = pc_q + 32'd4;
        end
    end

    // Fetch control state: FSM, PC and the skid buffer for stalled responses.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= REQ;
            pc_q    <= RESET_PC;
            // NOTE: the skid data is cleared too, although HOLD is its only valid flag, to keep it X-free after reset.
            skid_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if (capture) begin
                skid_q <= imem_rdata;
            end
        end
    end

    // IF/ID register: reset, then redirect bubble, then stall hold, then delivery, else bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            instD    <= NOP_INST;
            PCD      <= 32'd0;
            PCPlus4D <= 32'd0;
            validD   <= 1'b0;
        end else if (PCSrcE) begin
            instD  <= NOP_INST;
            validD <= 1'b0;
        end else if (stallD) begin
            instD    <= instD;
            PCD      <= PCD;
            PCPlus4D <= PCPlus4D;
            validD   <= validD;
        end else if (deliver) begin
            instD    <= deliver_word;
            PCD      <= pc_q;
            PCPlus4D <= pc_q + 32'd4;
            validD   <= 1'b1;
        end else begin
            instD  <= NOP_INST;
            validD <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed scenarios followed by randomized traffic.
// The stimulus side models the instruction memory and pushes the expected
// architectural instruction stream (sequential from the last redirect or
// reset) into a queue; a monitor pops it whenever IF/ID takes a new word.
module tb_fetch_sequencer;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallD;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic        validD;
    logic        stallF;

    fetch_sequencer #(.RESET_PC(RESET_PC), .NOP_INST(NOP)) dut (
        .clk        (clk),
        .rst        (rst),
        .stallD     (stallD),
        .PCSrcE     (PCSrcE),
        .PCTargetE  (PCTargetE),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .instD      (instD),
        .PCD        (PCD),
        .PCPlus4D   (PCPlus4D),
        .validD     (validD),
        .stallF     (stallF)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] tail_pc;
    int          n_pass   = 0;
    int          n_checks = 0;
    int          n_deliv  = 0;
    bit          mon_en   = 1'b0;

    // Memory model state: one outstanding response with a latency countdown.
    bit          pend     = 1'b0;
    int          pend_lat = 0;
    logic [31:0] pend_word;
    bit          ovr_en   = 1'b0;
    logic [31:0] ovr_word;
    int          lat_fixed = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0008) return 32'h0050_0093;
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0003;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic refill();
        while (exp_q.size() < 4) begin
            exp_q.push_back('{pc: tail_pc, word: mem_word(tail_pc)});
            tail_pc = tail_pc + 32'd4;
        end
    endtask

    // Apply one cycle of inputs; rdy: 0/1 fixed, 2 random.
    task automatic drive(input bit r, input bit st, input bit redir,
                         input logic [31:0] tgt, input int rdy);
        rst       = r;
        stallD    = st;
        PCSrcE    = redir;
        PCTargetE = tgt;
        if (redir) begin
            exp_q.delete();
            tail_pc = tgt & ~32'h3;
        end
        if (r) begin
            exp_q.delete();
            tail_pc = RESET_PC;
            pend    = 1'b0;
        end
        refill();
        if (pend && pend_lat == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = pend_word;
            pend        = 1'b0;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
            if (pend) pend_lat--;
        end
        imem_ready = (rdy == 2) ? 1'($urandom_range(0, 1)) : 1'(rdy);
        #1;
        if (!r && imem_req && imem_ready) begin
            pend      = 1'b1;
            pend_lat  = (lat_fixed < 0) ? int'($urandom_range(0, 3)) : lat_fixed;
            pend_word = ovr_en ? ovr_word : mem_word(imem_addr);
            ovr_en    = 1'b0;
        end
    endtask

    task automatic advance();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic check_ifid(input string name, input logic [31:0] inst, input logic [31:0] pc,
                              input logic [31:0] pc4, input bit v);
        check({name, "_inst"}, instD, inst);
        check({name, "_pc"}, PCD, pc);
        check({name, "_pc4"}, PCPlus4D, pc4);
        check({name, "_valid"}, 32'(validD), 32'(v));
    endtask

    // Monitor: tracks the expected IF/ID contents and compares every cycle.
    logic [31:0] m_inst, m_pc, m_pc4;
    bit          m_valid;
    exp_t        m_e;
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (rst) begin
                    m_inst = NOP; m_pc = 32'd0; m_pc4 = 32'd0; m_valid = 1'b0;
                end else if (PCSrcE) begin
                    m_inst = NOP; m_valid = 1'b0;
                end else if (stallD) begin
                    m_valid = m_valid;
                end else if (validD === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL mon_unexpected_delivery: got pc %h, expected no delivery", PCD);
                    end else begin
                        m_e     = exp_q.pop_front();
                        m_inst  = m_e.word;
                        m_pc    = m_e.pc;
                        m_pc4   = m_e.pc + 32'd4;
                        m_valid = 1'b1;
                        n_deliv++;
                    end
                end else begin
                    m_inst = NOP; m_valid = 1'b0;
                end
                check("mon_instD", instD, m_inst);
                check("mon_PCD", PCD, m_pc);
                check("mon_PCPlus4D", PCPlus4D, m_pc4);
                check("mon_validD", 32'(validD), 32'(m_valid));
            end
        end
    end

    bit          r_rst, r_st, r_rd;
    logic [31:0] r_tgt;
    logic [31:0] r_addr;

    initial begin
        rst = 1'b1; stallD = 1'b0; PCSrcE = 1'b0; PCTargetE = 32'd0;
        imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0;
        tail_pc = RESET_PC;
        mon_en  = 1'b1;

        // Reset: request suppressed while rst is high, IF/ID cleared.
        drive(1, 0, 0, 32'd0, 0);
        advance();
        drive(1, 0, 0, 32'd0, 1);
        check("req_in_reset", 32'(imem_req), 32'd0);
        advance();
        check_ifid("reset", NOP, 32'd0, 32'd0, 1'b0);

        // Straight-line fetch with a 1-cycle memory: one word every other cycle.
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 0, 32'd0, 1);
            check("seq_req", 32'(imem_req), 32'd1);
            check("seq_addr", imem_addr, 32'(4 * k));
            advance();
            check("seq_bubble", instD, NOP);
            drive(0, 0, 0, 32'd0, 1);
            check("seq_req_wait", 32'(imem_req), 32'd0);
            advance();
            check_ifid("seq", mem_word(32'(4 * k)), 32'(4 * k), 32'(4 * k + 4), 1'b1);
        end

        // Memory not ready for 3 cycles: request and address held, stallF high.
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 32'd0, 0);
            check("notready_req", 32'(imem_req), 32'd1);
            check("notready_addr", imem_addr, 32'h0000_000C);
            check("notready_stallF", 32'(stallF), 32'd1);
            advance();
        end
        drive(0, 0, 0, 32'd0, 1);
        check("ready_stallF", 32'(stallF), 32'd0);
        advance();
        drive(0, 0, 0, 32'd0, 1);
        advance();

        // Redirect in WAIT: the late 0xDEADBEEF response must never reach decode.
        ovr_en = 1'b1; ovr_word = 32'hDEAD_BEEF; lat_fixed = 1;
        drive(0, 0, 0, 32'd0, 1);
        advance();
        drive(0, 0, 1, 32'h0000_0100, 1);
        advance();
        check("redir_bubble_inst", instD, NOP);
        check("redir_bubble_valid", 32'(validD), 32'd0);
        drive(0, 0, 0, 32'd0, 1);
        check("flush_req", 32'(imem_req), 32'd0);
        advance();
        check("stale_dropped", instD, NOP);
        lat_fixed = 0;
        drive(0, 0, 0, 32'd0, 1);
        check("redir_addr", imem_addr, 32'h0000_0100);
        advance();
        drive(0, 0, 0, 32'd0, 1);
        advance();
        check("redir_deliver_pc", PCD, 32'h0000_0100);

        // Redirect in the same cycle as a handshake; target low bits masked.
        drive(0, 0, 1, 32'h0000_0203, 1);
        check("hs_redir_req", 32'(imem_req), 32'd1);
        advance();
        drive(0, 0, 0, 32'd0, 1);
        check("hs_redir_flush_req", 32'(imem_req), 32'd0);
        check("hs_redir_addr", imem_addr, 32'h0000_0200);
        advance();
        check("hs_redir_stale", 32'(validD), 32'd0);
        drive(0, 0, 0, 32'd0, 1);
        check("hs_redir_next", imem_addr, 32'h0000_0200);
        advance();
        drive(0, 0, 0, 32'd0, 1);
        advance();
        check("hs_redir_deliver_pc", PCD, 32'h0000_0200);

        // Decode stall across a response: IF/ID holds, skid buffer delivers later.
        drive(0, 0, 1, 32'h0000_0004, 0);
        advance();
        drive(0, 0, 0, 32'd0, 1);
        check("stall_pre_addr", imem_addr, 32'h0000_0004);
        advance();
        drive(0, 0, 0, 32'd0, 1);
        advance();
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 0, 32'd0, 1);
            if (i == 0) check("stall_addr", imem_addr, 32'h0000_0008);
            advance();
            check_ifid("stall_hold", mem_word(32'h4), 32'h4, 32'h8, 1'b1);
        end
        drive(0, 0, 0, 32'd0, 1);
        advance();
        check_ifid("stall_release", 32'h0050_0093, 32'h8, 32'hC, 1'b1);
        drive(0, 0, 0, 32'd0, 1);
        check("stall_next_addr", imem_addr, 32'h0000_000C);
        advance();

        // Reset while waiting for a response.
        drive(1, 0, 0, 32'd0, 1);
        check("midreset_req", 32'(imem_req), 32'd0);
        advance();
        check_ifid("midreset", NOP, 32'd0, 32'd0, 1'b0);
        drive(0, 0, 0, 32'd0, 0);
        check("midreset_req_after", 32'(imem_req), 32'd1);
        check("midreset_addr", imem_addr, RESET_PC);
        advance();

        // Wrap: delivery from 0xFFFF_FFFC gives PC+4 = 0 and next fetch at 0.
        drive(0, 0, 1, 32'hFFFF_FFFC, 0);
        advance();
        drive(0, 0, 0, 32'd0, 1);
        check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        advance();
        drive(0, 0, 0, 32'd0, 1);
        advance();
        check_ifid("wrap", mem_word(32'hFFFF_FFFC), 32'hFFFF_FFFC, 32'd0, 1'b1);
        drive(0, 0, 0, 32'd0, 1);
        check("wrap_next_addr", imem_addr, 32'd0);
        advance();
        drive(0, 0, 0, 32'd0, 1);
        advance();

        // Randomized traffic: stalls, redirects, resets, ready and latency.
        lat_fixed = -1;
        for (int c = 0; c < 4000; c++) begin
            r_rst = ($urandom_range(0, 199) == 0);
            r_st  = ($urandom_range(0, 9) < 3);
            r_rd  = !r_rst && ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 3) == 0) r_tgt = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            else r_tgt = $urandom & 32'h0000_0FFF;
            drive(r_rst, r_st, r_rd, r_tgt, 2);
            if (imem_req) begin
                r_addr = imem_addr;
                check("rand_addr_align", {30'd0, r_addr[1:0]}, 32'd0);
            end
            advance();
        end

        check("rand_deliveries", 32'(n_deliv >= 100), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
